apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator bridging the CPU's simple request port onto the shared APB bus.
//  Decodes the address to one of NUM_SLAVES slave selects, runs the SETUP/ACCESS
//  sequence, waits on the selected slave's PREADY and returns read data.
//  Sits between the CPU load/store path and the peripherals (UART, GPIO, timer...).
// PARAMETERS
//  NUM_SLAVES      4              number of APB slaves (1..16), one PSEL bit each
//  BASE_ADDR       32'h1000_0000  peripheral region base; bits [31:16] compared
//  TIMEOUT_CYCLES  16             max ACCESS cycles before abort (APB_TIMEOUT_EN only)
// PORTS
//  PCLK      in   1               clock
//  PRESET    in   1               reset, asynchronous, active-high
//  transfer  in   1               request strobe, sampled only in IDLE
//  write     in   1               1=write, 0=read (sampled with transfer)
//  addr      in   32              byte address (sampled with transfer)
//  wdata     in   32              write data (sampled with transfer)
//  rdata     out  32              read data, valid while ready=1
//  ready     out  1               1-cycle completion pulse
//  err       out  1               error flag, valid while ready=1
//  busy      out  1               1 in SETUP/ACCESS
//  PADDR     out  32              APB address
//  PWDATA    out  32              APB write data
//  PWRITE    out  1               APB direction
//  PENABLE   out  1               APB enable
//  PSEL      out  NUM_SLAVES      one-hot slave select
//  PRDATA_S  in   32*NUM_SLAVES   slave read data, slave i at [32*i+:32]
//  PREADY_S  in   NUM_SLAVES      slave ready, slave i at bit i
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; address/data registers 0.
//  - Decode: hit = addr[31:16]==BASE_ADDR[31:16] && addr[15:12]<NUM_SLAVES;
//    idx = addr[15:12]. Decode done once on capture, held in a register.
//  - States: IDLE, SETUP, ACCESS. All outputs registered.
//  - IDLE: transfer=1 & hit -> latch addr/wdata/write/idx, ->SETUP.
//    transfer=1 & !hit -> no PSEL, next cycle ready=1, err=1, rdata=0, stay IDLE.
//    transfer=0 -> stay. ready/err/rdata are pulses and clear after one cycle.
//  - SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWDATA/PWRITE driven -> ACCESS (1 cycle).
//  - ACCESS: PSEL[idx]=1, PENABLE=1. PREADY_S[idx]=1 -> ->IDLE; next cycle
//    ready=1, err=0, rdata=PRDATA_S[idx] on reads, 0 on writes;
//    PSEL/PENABLE drop to 0. PREADY_S[idx]=0 -> stay; PADDR/PWDATA/PWRITE stable.
//  - Only PREADY_S/PRDATA_S of the selected slave are observed; others are ignored.
//  - Latency: transfer at cycle N -> SETUP N+1 -> ACCESS N+2; PREADY high at
//    N+k (k>=2) -> ready at N+k+1. Minimum 3 cycles. Back-to-back: transfer may be
//    reasserted in the ready cycle (IDLE) and is accepted.
//  - transfer while busy=1 is ignored (no queuing); requester waits for ready.
//  - PADDR/PWDATA/PWRITE hold their last values in IDLE; they are not cleared.
//  - PRESET mid-transfer: immediate return to IDLE, PSEL/PENABLE=0, no ready pulse.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: 5-bit-min wait counter cleared on SETUP->ACCESS, counts
//    ACCESS cycles; reaching TIMEOUT_CYCLES with PREADY_S[idx]=0 aborts:
//    ->IDLE, PSEL/PENABLE=0, next cycle ready=1, err=1, rdata=0.
//    PREADY in the final counted cycle completes normally (no err).
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; err is set
//    only for unmapped addresses.
// TESTING
//  1. Write addr=0x1000_0008 wdata=0xA5, slave0 PREADY 1 cycle after PENABLE ->
//     PSEL=4'b0001, PADDR=0x1000_0008, PWDATA=0xA5, ready 4 cycles after transfer, err=0.
//  2. Read addr=0x1000_100C, slave1 PRDATA=0x0000_0042, PREADY at first ACCESS ->
//     PSEL=4'b0010, ready at cycle 3, rdata=0x42, err=0.
//  3. Unmapped addr=0x2000_0000 and addr=0x1000_4000 (NUM_SLAVES=4) -> PSEL never set,
//     ready+err next cycle, rdata=0.
//  4. Back-to-back read/write to slaves 2/3, transfer reasserted in ready cycle,
//     plus transfer pulses while busy -> both complete in order, busy pulses ignored.
//  5. Slave PREADY held low 20 cycles: with APB_TIMEOUT_EN ready+err after 16
//     ACCESS cycles; without it busy stays 1 until PREADY, then err=0.
//  6. PRESET asserted during ACCESS -> PSEL/PENABLE/busy/ready=0 same cycle, IDLE;
//     next transfer completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// CPU request port plus shared APB bus of the APB initiator bridge.
// Latency: none; this is wiring only.
// Backpressure: the requester waits for ready, and the bridge waits on the selected PREADY_S.
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  // CPU side
  logic                    transfer;
  logic                    write;
  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [31:0]             rdata;
  logic                    ready;
  logic                    err;
  logic                    busy;
  // APB side
  logic [31:0]             PADDR;
  logic [31:0]             PWDATA;
  logic                    PWRITE;
  logic                    PENABLE;
  logic [NUM_SLAVES-1:0]   PSEL;
  logic [32*NUM_SLAVES-1:0] PRDATA_S;
  logic [NUM_SLAVES-1:0]   PREADY_S;

  // Bridge view
  modport master (
    input  transfer, write, addr, wdata, PRDATA_S, PREADY_S,
    output rdata, ready, err, busy, PADDR, PWDATA, PWRITE, PENABLE, PSEL
  );

  // Requester/peripheral view
  modport slave (
    output transfer, write, addr, wdata, PRDATA_S, PREADY_S,
    input  rdata, ready, err, busy, PADDR, PWDATA, PWRITE, PENABLE, PSEL
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: decodes a CPU request to one of NUM_SLAVES PSELs and runs SETUP/ACCESS.
// Latency: at least 3 cycles from transfer to ready; unmapped addresses answer ready+err 1 cycle later.
// Backpressure: transfer is only accepted in IDLE. ACCESS waits on PREADY_S[idx], or aborts under APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_bridge_if.master bus
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q;
  logic [31:0]           paddr_q;
  logic [31:0]           pwdata_q;
  logic                  pwrite_q;
  logic                  penable_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic [IW-1:0]         idx_q;
  logic [31:0]           rdata_q;
  logic                  ready_q;
  logic                  err_q;
  logic                  busy_q;

  logic                  hit_d;
  logic [IW-1:0]         idx_d;
  logic [NUM_SLAVES-1:0] sel_d;
  logic                  pready_sel;
  logic [31:0]           prdata_sel;
  logic                  tmo_d;

  // Address decode of the incoming request: region match and slave index in range.
  always_comb begin
    hit_d = (bus.addr[31:16] == BASE_ADDR[31:16]) &&
            ({28'd0, bus.addr[15:12]} < 32'(NUM_SLAVES));
    idx_d = bus.addr[12 +: IW];
    sel_d = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_d[i] = (idx_d == IW'(i));
    end
  end

  // Only the latched slave's PREADY/PRDATA are looked at; all others are masked.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        pready_sel = bus.PREADY_S[i];
        prdata_sel = bus.PRDATA_S[32*i +: 32];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  logic [CW-1:0] wait_cnt_q;
  // The abort fires at the end of the TIMEOUT_CYCLES-th ACCESS cycle, unless PREADY arrives in that cycle.
  always_comb tmo_d = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  always_comb tmo_d = 1'b0;
`endif

  // Bridge FSM: all CPU and APB outputs are registered here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      // The completion outputs are one-cycle pulses.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.transfer) begin
            if (hit_d) begin
              paddr_q  <= bus.addr;
              pwdata_q <= bus.wdata;
              pwrite_q <= bus.write;
              idx_q    <= idx_d;
              psel_q   <= sel_d;
              busy_q   <= 1'b1;
              state_q  <= SETUP;
            end else begin
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (pready_sel) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            rdata_q   <= pwrite_q ? 32'd0 : prdata_sel;
            state_q   <= IDLE;
          end else if (tmo_d) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PENABLE = penable_q;
  assign bus.PSEL    = psel_q;
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a response scoreboard and an APB transfer scoreboard, with per-slave wait models.
// Latency: every expected ready carries the absolute cycle at which it must appear.
// Backpressure: each slave holds PREADY low for wait_cyc[i] ACCESS cycles.
module tb_apb_master_bridge;
  localparam int NS = 4;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.NUM_SLAVES(NS)) bus ();

  apb_master_bridge #(
    .NUM_SLAVES(NS), .BASE_ADDR(32'h1000_0000), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );

  typedef struct {logic [31:0] rdata; logic err; int cyc;} rsp_t;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic write; logic [NS-1:0] sel;} apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  rsp_t mr;
  apb_t ma;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt;
  int wait_cyc[NS];
  logic [31:0] slv_rd[NS];
  bit psel_seen;
  int rs, rw;
  logic [31:0] ra, rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave wait model: counts ACCESS cycles spent without PREADY.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) acc_cnt <= 0;
    else if (bus.PENABLE && ((bus.PREADY_S & bus.PSEL) == '0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    bus.PREADY_S = '0;
    bus.PRDATA_S = '0;
    for (int i = 0; i < NS; i++) begin
      bus.PREADY_S[i] = bus.PSEL[i] && bus.PENABLE && (acc_cnt >= wait_cyc[i]);
      bus.PRDATA_S[32*i +: 32] = slv_rd[i];
    end
  end

  // Monitors: the CPU response and the completed APB transfer.
  always @(negedge PCLK) begin
    if (|bus.PSEL) psel_seen = 1'b1;
    if (!PRESET && bus.ready) begin
      check_eq("ready_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        mr = rsp_q.pop_front();
        check_eq("rdata", 64'(bus.rdata), 64'(mr.rdata));
        check_eq("err", 64'(bus.err), 64'(mr.err));
        check_eq("ready_cycle", 64'(cyc), 64'(mr.cyc));
      end
    end
    if (!PRESET && bus.PENABLE && ((bus.PREADY_S & bus.PSEL) != '0)) begin
      check_eq("apb_expected", 64'(apb_q.size() != 0), 64'd1);
      if (apb_q.size() != 0) begin
        ma = apb_q.pop_front();
        check_eq("PADDR", 64'(bus.PADDR), 64'(ma.addr));
        check_eq("PSEL", 64'(bus.PSEL), 64'(ma.sel));
        check_eq("PWRITE", 64'(bus.PWRITE), 64'(ma.write));
        if (ma.write) check_eq("PWDATA", 64'(bus.PWDATA), 64'(ma.wdata));
      end
    end
  end

  // Called at a negedge: drive one transfer cycle and record the expectations.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input bit mapped, input int s);
    logic [NS-1:0] sel;
    sel = '0;
    sel[s] = 1'b1;
    bus.transfer = 1'b1;
    bus.write = w;
    bus.addr = a;
    bus.wdata = d;
    rsp_q.push_back('{exp_rd, exp_err, cyc + lat});
    if (mapped) apb_q.push_back('{a, d, w, sel});
    @(negedge PCLK);
    bus.transfer = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (rsp_q.size() == 0 && apb_q.size() == 0) break;
      @(negedge PCLK);
    end
    check_eq("drain_rsp", 64'(rsp_q.size()), 64'd0);
    check_eq("drain_apb", 64'(apb_q.size()), 64'd0);
    rsp_q.delete();
    apb_q.delete();
    @(negedge PCLK);
  endtask

  task automatic wait_ready(input int max);
    int i;
    i = 0;
    do begin
      @(negedge PCLK);
      i++;
    end while (!bus.ready && i < max);
    check_eq("wait_ready", 64'(bus.ready), 64'd1);
  endtask

  initial begin
    bus.transfer = 1'b0;
    bus.write = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    for (int i = 0; i < NS; i++) begin
      wait_cyc[i] = 0;
      slv_rd[i] = 32'hC0DE_0000 + 32'(i);
    end
    #2;
    check_eq("rst_rdata", 64'(bus.rdata), 64'd0);
    check_eq("rst_ready", 64'(bus.ready), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_paddr", 64'(bus.PADDR), 64'd0);
    check_eq("rst_pwdata", 64'(bus.PWDATA), 64'd0);
    check_eq("rst_pwrite", 64'(bus.PWRITE), 64'd0);
    check_eq("rst_penable", 64'(bus.PENABLE), 64'd0);
    check_eq("rst_psel", 64'(bus.PSEL), 64'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Write to slave 0 with one wait state: ready 4 cycles after transfer.
    wait_cyc[0] = 1;
    issue(1'b1, 32'h1000_0008, 32'h0000_00A5, 32'd0, 1'b0, 4, 1'b1, 0);
    drain();

    // Read from slave 1 with no wait state: minimum latency of 3.
    slv_rd[1] = 32'h0000_0042;
    issue(1'b0, 32'h1000_100C, 32'd0, 32'h42, 1'b0, 3, 1'b1, 1);
    drain();

    // Unmapped region, then an out-of-range slave index, issued back to back.
    psel_seen = 1'b0;
    issue(1'b0, 32'h2000_0000, 32'd0, 32'd0, 1'b1, 1, 1'b0, 0);
    issue(1'b1, 32'h1000_4000, 32'h77, 32'd0, 1'b1, 1, 1'b0, 0);
    drain();
    check_eq("unmapped_psel", 64'(psel_seen), 64'd0);

    // Back-to-back read on slave 2 and write on slave 3; transfers issued while busy must be dropped.
    slv_rd[2] = 32'hBEEF_0002;
    wait_cyc[2] = 2;
    wait_cyc[3] = 0;
    issue(1'b0, 32'h1000_2010, 32'h1111, 32'hBEEF_0002, 1'b0, 5, 1'b1, 2);
    check_eq("busy_setup", 64'(bus.busy), 64'd1);
    bus.transfer = 1'b1; bus.write = 1'b1; bus.addr = 32'h1000_3000;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    wait_ready(20);
    issue(1'b1, 32'h1000_3004, 32'hCAFE_F00D, 32'd0, 1'b0, 3, 1'b1, 3);
    bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_2000;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    drain();

    // Slave 0 stalls for 20 cycles.
    wait_cyc[0] = 20;
`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h1000_0020, 32'd0, 32'd0, 1'b1, 18, 1'b0, 0);
`else
    issue(1'b0, 32'h1000_0020, 32'd0, slv_rd[0], 1'b0, 23, 1'b1, 0);
`endif
    repeat (10) @(negedge PCLK);
    check_eq("busy_waiting", 64'(bus.busy), 64'd1);
    drain();

    // PREADY arrives in the 16th ACCESS cycle: this completes normally in either build.
    wait_cyc[0] = 15;
    issue(1'b0, 32'h1000_0024, 32'd0, slv_rd[0], 1'b0, 18, 1'b1, 0);
    drain();

    // Reset asserted during ACCESS.
    wait_cyc[1] = 30;
    issue(1'b0, 32'h1000_1000, 32'd0, slv_rd[1], 1'b0, 33, 1'b1, 1);
    repeat (3) @(negedge PCLK);
    check_eq("penable_pre_rst", 64'(bus.PENABLE), 64'd1);
    PRESET = 1'b1;
    #1;
    check_eq("rst_mid_psel", 64'(bus.PSEL), 64'd0);
    check_eq("rst_mid_penable", 64'(bus.PENABLE), 64'd0);
    check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_mid_ready", 64'(bus.ready), 64'd0);
    rsp_q.delete();
    apb_q.delete();
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    wait_cyc[1] = 0;
    issue(1'b0, 32'h1000_1000, 32'd0, slv_rd[1], 1'b0, 3, 1'b1, 1);
    drain();

    // Mixed random traffic; index 4 exercises the unmapped path.
    for (int k = 0; k < 8; k++) begin
      rs = $urandom_range(0, 4);
      rw = $urandom_range(0, 1);
      rd = $urandom;
      ra = 32'h1000_0000 + 32'(rs) * 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      if (rs == 4) begin
        issue(rw[0], ra, rd, 32'd0, 1'b1, 1, 1'b0, 0);
      end else begin
        wait_cyc[rs] = $urandom_range(0, 3);
        slv_rd[rs] = $urandom;
        issue(rw[0], ra, rd, rw[0] ? 32'd0 : slv_rd[rs], 1'b0, 3 + wait_cyc[rs], 1'b1, rs);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
